// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the ID/IX pipeline datapath and pipeline_hazard_ctrl.
// master = pipeline side (drives hazard status), slave = hazard controller.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic              id_rs1_used;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs2_used;
  logic              ix_is_load;
  logic [REG_AW-1:0] ix_rd;
  logic              ix_br_taken;
  logic              ix_mc_busy;
  logic              pc_we;
  logic              if_id_we;
  logic              if_id_flush;
  logic              id_ix_we;
  logic              id_ix_bubble;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              busy;

  modport master (
    output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    output ix_is_load, ix_rd, ix_br_taken, ix_mc_busy,
    input  pc_we, if_id_we, if_id_flush, id_ix_we, id_ix_bubble,
    input  stall_cnt, flush_cnt, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
    input  ix_is_load, ix_rd, ix_br_taken, ix_mc_busy,
    output pc_we, if_id_we, if_id_flush, id_ix_we, id_ix_bubble,
    output stall_cnt, flush_cnt, busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// IF/ID and ID/IX sequencing: load-use bubbles, taken-branch squash, multicycle freeze,
// plus saturating stall/flush performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam int unsigned FC_W = 3;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_FLUSH  = 2'd1,
    S_MCWAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [FC_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]  stall_q, flush_q;
  logic              stall_inc, flush_inc;
  logic              ld_hz;
  logic              pc_we_c, if_id_we_c, if_id_flush_c, id_ix_we_c, id_ix_bubble_c;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign ld_hz = hz.id_valid & hz.ix_is_load & (hz.ix_rd != '0) &
                 ((hz.id_rs1_used & (hz.id_rs1 == hz.ix_rd)) |
                  (hz.id_rs2_used & (hz.id_rs2 == hz.ix_rd)));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_we_c        = 1'b1;
    if_id_we_c     = 1'b1;
    id_ix_we_c     = 1'b1;
    if_id_flush_c  = 1'b0;
    id_ix_bubble_c = 1'b0;
    stall_inc      = 1'b0;
    flush_inc      = 1'b0;

    unique case (state_q)
      S_RUN: begin
        if (hz.ix_br_taken) begin
          if_id_flush_c  = 1'b1;
          id_ix_bubble_c = 1'b1;
          flush_inc      = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            cnt_d   = FC_W'(FLUSH_CYCLES - 1);
          end
        end else if (hz.ix_mc_busy) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          id_ix_we_c = 1'b0;
          stall_inc  = 1'b1;
          state_d    = S_MCWAIT;
        end else if (ld_hz) begin
          pc_we_c        = 1'b0;
          if_id_we_c     = 1'b0;
          id_ix_bubble_c = 1'b1;
          stall_inc      = 1'b1;
        end
      end
      S_FLUSH: begin
        if_id_flush_c  = 1'b1;
        id_ix_bubble_c = 1'b1;
        cnt_d          = cnt_q - FC_W'(1);
        if (cnt_q <= FC_W'(1)) state_d = S_RUN;
      end
      S_MCWAIT: begin
        if (hz.ix_mc_busy) begin
          pc_we_c    = 1'b0;
          if_id_we_c = 1'b0;
          id_ix_we_c = 1'b0;
          stall_inc  = 1'b1;
        end else begin
          state_d = S_RUN;
          // The instruction released from ID may still depend on a load now in IX.
          if (ld_hz) begin
            pc_we_c        = 1'b0;
            if_id_we_c     = 1'b0;
            id_ix_bubble_c = 1'b1;
            stall_inc      = 1'b1;
          end
        end
      end
      default: state_d = S_RUN;
    endcase

    // While reset is held the pipeline free-runs regardless of hazard inputs.
    if (!rst_n) begin
      pc_we_c        = 1'b1;
      if_id_we_c     = 1'b1;
      id_ix_we_c     = 1'b1;
      if_id_flush_c  = 1'b0;
      id_ix_bubble_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (stall_inc && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
      if (flush_inc && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign hz.pc_we        = pc_we_c;
  assign hz.if_id_we     = if_id_we_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ix_we     = id_ix_we_c;
  assign hz.id_ix_bubble = id_ix_bubble_c;
  assign hz.stall_cnt    = stall_q;
  assign hz.flush_cnt    = flush_q;
  assign hz.busy         = (state_q != S_RUN);

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed vector table, reset/saturation sequences,
// and random traffic against a cycle-level behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned FC     = 2;
  localparam int unsigned CNT_W  = 5;
  localparam int          MAXC   = 31;

  localparam logic [5:0] C_NORM  = 6'b110100;
  localparam logic [5:0] C_LDST  = 6'b000110;
  localparam logic [5:0] C_BR    = 6'b111110;
  localparam logic [5:0] C_FLSH  = 6'b111111;
  localparam logic [5:0] C_MC0   = 6'b000000;
  localparam logic [5:0] C_MCW   = 6'b000001;
  localparam logic [5:0] C_MCX   = 6'b110101;
  localparam logic [5:0] C_MCXLD = 6'b000111;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  pipeline_hazard_ctrl_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz_if ();

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .FLUSH_CYCLES(FC), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       va;
    int         r1;
    logic       u1;
    int         r2;
    logic       u2;
    logic       ld;
    int         rd;
    logic       br;
    logic       mc;
    logic [5:0] ctl;
    int         st;
    int         fl;
  } vec_t;

  function automatic vec_t mkv(input logic va, input int r1, input logic u1, input int r2,
                               input logic u2, input logic ld, input int rd, input logic br,
                               input logic mc, input logic [5:0] ctl, input int st, input int fl);
    vec_t v;
    v.va = va; v.r1 = r1; v.u1 = u1; v.r2 = r2; v.u2 = u2; v.ld = ld; v.rd = rd;
    v.br = br; v.mc = mc; v.ctl = ctl; v.st = st; v.fl = fl;
    return v;
  endfunction

  task automatic drive(input logic va, input int r1, input logic u1, input int r2,
                       input logic u2, input logic ld, input int rd, input logic br,
                       input logic mc);
    hz_if.id_valid    = va;
    hz_if.id_rs1      = REG_AW'(r1);
    hz_if.id_rs1_used = u1;
    hz_if.id_rs2      = REG_AW'(r2);
    hz_if.id_rs2_used = u2;
    hz_if.ix_is_load  = ld;
    hz_if.ix_rd       = REG_AW'(rd);
    hz_if.ix_br_taken = br;
    hz_if.ix_mc_busy  = mc;
  endtask

  task automatic check(input string name, input logic [5:0] ectl, input int est, input int efl);
    logic [5:0] act;
    act = {hz_if.pc_we, hz_if.if_id_we, hz_if.if_id_flush,
           hz_if.id_ix_we, hz_if.id_ix_bubble, hz_if.busy};
    n_tests++;
    if (act !== ectl) begin
      n_fail++;
      $display("FAIL %s ctl {pc,ifid,flush,idix,bubble,busy}: got %b expected %b", name, act, ectl);
    end
    n_tests++;
    if (int'(hz_if.stall_cnt) != est || int'(hz_if.flush_cnt) != efl) begin
      n_fail++;
      $display("FAIL %s counters: got stall=%0d flush=%0d expected stall=%0d flush=%0d",
               name, hz_if.stall_cnt, hz_if.flush_cnt, est, efl);
    end
  endtask

  vec_t vecs[23];

  // Reference model state: remaining squash cycles, freeze flag, counters.
  int   m_squash;
  bit   m_frozen;
  int   m_stall;
  int   m_flush;

  initial begin
    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_NORM,  0, 0);
    vecs[1]  = mkv(1, 5, 1, 2, 1, 1, 5, 0, 0, C_LDST,  0, 0);
    vecs[2]  = mkv(1, 5, 1, 2, 1, 0, 5, 0, 0, C_NORM,  1, 0);
    vecs[3]  = mkv(1, 0, 1, 0, 1, 1, 0, 0, 0, C_NORM,  1, 0);
    vecs[4]  = mkv(1, 3, 0, 7, 1, 1, 7, 0, 0, C_LDST,  1, 0);
    vecs[5]  = mkv(1, 7, 0, 9, 0, 1, 7, 0, 0, C_NORM,  2, 0);
    vecs[6]  = mkv(0, 5, 1, 5, 1, 1, 5, 0, 0, C_NORM,  2, 0);
    vecs[7]  = mkv(1, 5, 1, 2, 1, 1, 5, 1, 0, C_BR,    2, 0);
    vecs[8]  = mkv(1, 5, 1, 2, 1, 1, 5, 1, 1, C_FLSH,  2, 1);
    vecs[9]  = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_NORM,  2, 1);
    vecs[10] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 1, C_MC0,   2, 1);
    vecs[11] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 1, C_MCW,   3, 1);
    vecs[12] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 1, C_MCW,   4, 1);
    vecs[13] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_MCX,   5, 1);
    vecs[14] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_NORM,  5, 1);
    vecs[15] = mkv(1, 1, 1, 2, 1, 0, 0, 1, 1, C_BR,    5, 1);
    vecs[16] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 1, C_FLSH,  5, 2);
    vecs[17] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 1, C_MC0,   5, 2);
    vecs[18] = mkv(1, 4, 1, 2, 1, 1, 4, 0, 0, C_MCXLD, 6, 2);
    vecs[19] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_NORM,  7, 2);
    vecs[20] = mkv(1, 6, 1, 2, 1, 1, 6, 0, 1, C_MC0,   7, 2);
    vecs[21] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_MCX,   8, 2);
    vecs[22] = mkv(1, 1, 1, 2, 1, 0, 0, 0, 0, C_NORM,  8, 2);

    // Reset with a live load-use pattern on the inputs: outputs must still free-run.
    rst_n = 1'b0;
    drive(1, 5, 1, 2, 1, 1, 5, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset", C_NORM, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1, 1, 1, 2, 1, 0, 0, 0, 0);

    for (int i = 0; i < 23; i++) begin
      if (i > 0) begin
        @(posedge clk);
        #1;
      end
      drive(vecs[i].va, vecs[i].r1, vecs[i].u1, vecs[i].r2, vecs[i].u2,
            vecs[i].ld, vecs[i].rd, vecs[i].br, vecs[i].mc);
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].ctl, vecs[i].st, vecs[i].fl);
    end

    // Reset asserted in the last squash cycle aborts the flush immediately.
    @(posedge clk); #1;
    drive(1, 1, 1, 2, 1, 0, 0, 1, 0);
    @(negedge clk);
    check("rst_br", C_BR, 8, 2);
    @(posedge clk); #1;
    drive(1, 3, 1, 2, 1, 1, 3, 0, 0);
    @(negedge clk);
    check("rst_in_flush", C_FLSH, 8, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_abort", C_NORM, 0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1, 1, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("rst_release", C_NORM, 0, 0);

    // Saturation: long freeze, then back-to-back taken branches.
    @(posedge clk); #1;
    drive(1, 1, 1, 2, 1, 0, 0, 0, 1);
    repeat (40) @(posedge clk);
    #1;
    drive(1, 1, 1, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_stall", C_MCX, MAXC, 0);
    @(posedge clk); #1;
    drive(1, 1, 1, 2, 1, 0, 0, 1, 0);
    repeat (80) @(posedge clk);
    #1;
    drive(1, 1, 1, 2, 1, 0, 0, 0, 0);
    @(negedge clk);
    check("sat_flush", C_NORM, MAXC, MAXC);

    // Random traffic against the behavioural model, starting from a fresh reset.
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n    = 1'b1;
    m_squash = 0;
    m_frozen = 1'b0;
    m_stall  = 0;
    m_flush  = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      logic va, u1, u2, ld, br, mc, hzd, do_rst;
      int r1, r2, rd;
      logic [5:0] e;
      bit fr_n;
      int sq_n, dst, dfl;
      if (cyc > 0) begin
        @(posedge clk);
        #1;
      end
      do_rst = ($urandom_range(59) == 0);
      va = ($urandom_range(4) != 0);
      r1 = $urandom_range(3);
      u1 = 1'($urandom_range(1));
      r2 = $urandom_range(3);
      u2 = 1'($urandom_range(1));
      ld = 1'($urandom_range(1));
      rd = $urandom_range(3);
      br = ($urandom_range(9) == 0);
      mc = ($urandom_range(6) == 0) || (m_frozen && $urandom_range(1) == 1);
      rst_n = !do_rst;
      drive(va, r1, u1, r2, u2, ld, rd, br, mc);
      hzd = va && ld && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
      sq_n = m_squash;
      fr_n = m_frozen;
      dst = 0;
      dfl = 0;
      if (do_rst) begin
        e = C_NORM;
        m_stall = 0;
        m_flush = 0;
        sq_n = 0;
        fr_n = 1'b0;
      end else if (m_squash > 0) begin
        e = C_FLSH;
        sq_n = m_squash - 1;
      end else if (m_frozen) begin
        if (mc) begin
          e = C_MCW;
          dst = 1;
        end else begin
          fr_n = 1'b0;
          e = hzd ? C_MCXLD : C_MCX;
          dst = hzd ? 1 : 0;
        end
      end else if (br) begin
        e = C_BR;
        dfl = 1;
        sq_n = FC - 1;
      end else if (mc) begin
        e = C_MC0;
        dst = 1;
        fr_n = 1'b1;
      end else if (hzd) begin
        e = C_LDST;
        dst = 1;
      end else begin
        e = C_NORM;
      end
      @(negedge clk);
      check($sformatf("rnd%0d", cyc), e, m_stall, m_flush);
      m_squash = sq_n;
      m_frozen = fr_n;
      m_stall  = (m_stall + dst > MAXC) ? MAXC : m_stall + dst;
      m_flush  = (m_flush + dfl > MAXC) ? MAXC : m_flush + dfl;
    end
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
